// File: rtl/nmos_famux_arbiter.sv
// Round-robin arbiter driving the one-hot SA/SB/SC selects and FF force-high of a 3-source FAMUX.
// Define NMOS_FAMUX_PRECHARGE_EN to insert a one-cycle precharge gap on every owner change.
module nmos_famux_arbiter #(
    parameter int HOLD_W   = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic       main_clk,
    input  logic       rst_n,
    input  logic [2:0] REQ,
    output logic [2:0] GNT,
    output logic       SA,
    output logic       SB,
    output logic       SC,
    output logic       FF,
    output logic [1:0] OWNER,
    output logic       BUSY
);
    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        PRECH
    } state_t;

    localparam logic [HOLD_W-1:0] MAX_CNT = HOLD_W'(MAX_HOLD);
    localparam logic [1:0]        NONE    = 2'd3;

    state_t            state, state_d;
    logic [1:0]        ptr, ptr_d, owner_d;
    logic [2:0]        gnt_d;
    logic [HOLD_W-1:0] cnt, cnt_d;
    logic [1:0]        pick_all, pick_oth;
    logic              own_req;

    // First set bit scanning last+1, last+2, last; 3 when nothing requests.
    function automatic logic [1:0] rr_pick(input logic [2:0] req,
                                           input logic [1:0] last);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = NONE;
        for (int i = 3; i >= 1; i--) begin
            idx = 2'((int'(last) + i) % 3);
            if (req[idx]) pick = idx;
        end
        return pick;
    endfunction

    function automatic logic [2:0] dec(input logic [1:0] idx);
        return 3'(3'b001 << idx);
    endfunction

    assign pick_all = rr_pick(REQ, ptr);
    assign pick_oth = rr_pick(REQ & ~GNT, ptr);
    assign own_req  = |(REQ & GNT);

    always_comb begin
        state_d = state;
        gnt_d   = GNT;
        owner_d = OWNER;
        ptr_d   = ptr;
        cnt_d   = cnt;
        unique case (state)
            IDLE, PRECH: begin
                if (pick_all != NONE) begin
                    state_d = GRANT;
                    gnt_d   = dec(pick_all);
                    owner_d = pick_all;
                    ptr_d   = pick_all;
                    cnt_d   = HOLD_W'(1);
                end else begin
                    state_d = IDLE;
                    gnt_d   = 3'b000;
                    owner_d = NONE;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (own_req && cnt < MAX_CNT) begin
                    cnt_d = cnt + 1'b1;
                end else if (pick_oth != NONE) begin
`ifdef NMOS_FAMUX_PRECHARGE_EN
                    state_d = PRECH;
                    gnt_d   = 3'b000;
                    owner_d = NONE;
                    cnt_d   = '0;
`else
                    gnt_d   = dec(pick_oth);
                    owner_d = pick_oth;
                    ptr_d   = pick_oth;
                    cnt_d   = HOLD_W'(1);
`endif
                end else if (!own_req) begin
                    state_d = IDLE;
                    gnt_d   = 3'b000;
                    owner_d = NONE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 3'b000;
                owner_d = NONE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            GNT   <= 3'b000;
            OWNER <= NONE;
            ptr   <= 2'd2;
            cnt   <= '0;
        end else begin
            state <= state_d;
            GNT   <= gnt_d;
            OWNER <= owner_d;
            ptr   <= ptr_d;
            cnt   <= cnt_d;
        end
    end

    assign SA   = GNT[0];
    assign SB   = GNT[1];
    assign SC   = GNT[2];
    assign BUSY = |GNT;
    assign FF   = ~BUSY;

endmodule

// File: tb/tb_nmos_famux_arbiter.sv
// Scoreboard bench for nmos_famux_arbiter: directed REQ vectors push expected GNT,
// a negedge monitor pops and compares, and checks one-hot / FF invariants every cycle.
module tb_nmos_famux_arbiter;
    logic       main_clk = 1'b0;
    logic       rst_n    = 1'b0;
    logic [2:0] REQ      = 3'b000;
    logic [2:0] GNT;
    logic       SA, SB, SC, FF, BUSY;
    logic [1:0] OWNER;

    typedef struct {
        int         cyc;
        logic [2:0] gnt;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    nmos_famux_arbiter #(.HOLD_W(4), .MAX_HOLD(8)) dut (
        .main_clk (main_clk),
        .rst_n    (rst_n),
        .REQ      (REQ),
        .GNT      (GNT),
        .SA       (SA),
        .SB       (SB),
        .SC       (SC),
        .FF       (FF),
        .OWNER    (OWNER),
        .BUSY     (BUSY)
    );

    always #5 main_clk = ~main_clk;

    always @(posedge main_clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", nm, cyc, act, req);
        end
    endtask

    function automatic int owner_of(input logic [2:0] g);
        unique case (1'b1)
            g[0]:    return 0;
            g[1]:    return 1;
            g[2]:    return 2;
            default: return 3;
        endcase
    endfunction

    // Monitor: invariants every cycle, scoreboard compare when an entry is due.
    always @(negedge main_clk) begin
        exp_t e;
        check("onehot0", int'($onehot0(GNT)), 1);
        check("ff_not_busy", int'(FF == ~BUSY), 1);
        check("sel_no_overlap", int'($onehot0({SC, SB, SA})), 1);
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL stale_entry cycle=%0d actual=none required=%0d", cyc, e.gnt);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            check("gnt", int'(GNT), int'(e.gnt));
            check("sel", int'({SC, SB, SA}), int'(e.gnt));
            check("owner", int'(OWNER), owner_of(e.gnt));
            check("busy", int'(BUSY), int'(|e.gnt));
        end
    end

    task automatic step(input logic [2:0] r, input logic [2:0] g);
        REQ = r;
        q.push_back('{cyc + 1, g});
        @(negedge main_clk);
    endtask

    task automatic rr_seg(input logic [2:0] g, input bit first);
`ifdef NMOS_FAMUX_PRECHARGE_EN
        if (!first) step(3'b111, 3'b000);
`else
        if (!first) begin end
`endif
        repeat (8) step(3'b111, g);
    endtask

    task automatic do_reset();
        @(posedge main_clk);
        #2;
        rst_n = 1'b0;
        REQ   = 3'b000;
        repeat (2) @(negedge main_clk);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge main_clk);
        check("rst_gnt", int'(GNT), 0);
        check("rst_ff", int'(FF), 1);
        check("rst_owner", int'(OWNER), 3);
        check("rst_busy", int'(BUSY), 0);
        rst_n = 1'b1;

        // Single request then release
        step(3'b010, 3'b010);
        step(3'b010, 3'b010);
        step(3'b000, 3'b000);
        step(3'b000, 3'b000);

        // Lone requester saturates the hold counter and keeps the grant
        repeat (20) step(3'b001, 3'b001);
        step(3'b000, 3'b000);

        // Non-owner request withdrawn before service is lost
        step(3'b001, 3'b001);
        step(3'b011, 3'b001);
        step(3'b011, 3'b001);
        step(3'b001, 3'b001);
        step(3'b000, 3'b000);

        // Owner 0 drops while C requests
        step(3'b001, 3'b001);
`ifdef NMOS_FAMUX_PRECHARGE_EN
        step(3'b100, 3'b000);
`endif
        step(3'b100, 3'b100);
        step(3'b100, 3'b100);
        step(3'b000, 3'b000);

        // Owner 0 drops with B and C pending: B is next after 0
        step(3'b001, 3'b001);
`ifdef NMOS_FAMUX_PRECHARGE_EN
        step(3'b110, 3'b000);
`endif
        step(3'b110, 3'b010);
        step(3'b000, 3'b000);

        // Asynchronous reset mid-grant
        step(3'b100, 3'b100);
        step(3'b100, 3'b100);
        @(posedge main_clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_gnt", int'(GNT), 0);
        check("async_rst_ff", int'(FF), 1);
        check("async_rst_owner", int'(OWNER), 3);
        REQ = 3'b000;
        repeat (2) @(negedge main_clk);
        rst_n = 1'b1;

        // Round robin with all requesting: 0,1,2,0 for 8 cycles each
        rr_seg(3'b001, 1'b1);
        rr_seg(3'b010, 1'b0);
        rr_seg(3'b100, 1'b0);
        rr_seg(3'b001, 1'b0);
        step(3'b000, 3'b000);

        do_reset();
        step(3'b111, 3'b001);
        step(3'b000, 3'b000);

        repeat (3) @(negedge main_clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
